// File: rtl/booth_encoder_unit_pkg.sv
// Shared contract between the radix-8 Booth front end and the selector array:
// default widths, select-word layout and the select types.
package r8_mbe_pkg;

    localparam int XW    = 24;
    localparam int YW    = 24;
    localparam int PPW   = XW + 3;
    localparam int NPP   = (YW + 3) / 3;

    localparam int SEL_W   = 5;
    localparam int SEL_NEG = 4;
    localparam int SEL_4   = 3;
    localparam int SEL_3   = 2;
    localparam int SEL_2   = 1;
    localparam int SEL_1   = 0;

    typedef logic [SEL_W-1:0] sel_t;
    typedef sel_t [NPP-1:0]   sel_vec_t;

endpackage

// File: rtl/booth_encoder_unit_if.sv
// Operand/result bus of the Booth front end, with flush carried alongside.
interface booth_encoder_unit_if
    import r8_mbe_pkg::sel_t;
#(
    parameter int XW = r8_mbe_pkg::XW,
    parameter int YW = r8_mbe_pkg::YW
);
    localparam int PPW = XW + 3;
    localparam int NPP = (YW + 3) / 3;

    // A transfer happens on a clock edge where valid & ready are both high;
    // valid/data never depend on ready, ready may depend on the far side's ready.
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [XW-1:0]    x_in;
    logic [YW-1:0]    y_in;
    logic             out_valid;
    logic             out_ready;
    logic [PPW-1:0]   x_1;
    logic [PPW-1:0]   x_2;
    logic [PPW-1:0]   x_3;
    logic [PPW-1:0]   x_4;
    sel_t [NPP-1:0]   beu_sel;

    modport master (
        output flush, in_valid, x_in, y_in, out_ready,
        input  in_ready, out_valid, x_1, x_2, x_3, x_4, beu_sel
    );

    modport slave (
        input  flush, in_valid, x_in, y_in, out_ready,
        output in_ready, out_valid, x_1, x_2, x_3, x_4, beu_sel
    );

endinterface

// File: rtl/booth_encoder_unit_booth_encoder.sv
// One radix-8 Booth digit: window {y[3i+2], y[3i+1], y[3i], y[3i-1]} to a
// sign plus one-hot magnitude select word.
module booth_encoder
    import r8_mbe_pkg::*;
(
    input  logic [3:0] win,
    output sel_t       sel
);

    always_comb begin
        sel = '0;
        case (win)
            4'b0001, 4'b0010: sel[SEL_1] = 1'b1;
            4'b0011, 4'b0100: sel[SEL_2] = 1'b1;
            4'b0101, 4'b0110: sel[SEL_3] = 1'b1;
            4'b0111:          sel[SEL_4] = 1'b1;
            4'b1000: begin
                sel[SEL_NEG] = 1'b1;
                sel[SEL_4]   = 1'b1;
            end
            4'b1001, 4'b1010: begin
                sel[SEL_NEG] = 1'b1;
                sel[SEL_3]   = 1'b1;
            end
            4'b1011, 4'b1100: begin
                sel[SEL_NEG] = 1'b1;
                sel[SEL_2]   = 1'b1;
            end
            4'b1101, 4'b1110: begin
                sel[SEL_NEG] = 1'b1;
                sel[SEL_1]   = 1'b1;
            end
            // 0000 and 1111 are both zero digits and stay positive
            default: sel = '0;
        endcase
    end

endmodule

// File: rtl/booth_encoder_unit.sv
// Two-stage front end of the R8 MBE multiplier: S1 holds X and the Booth
// selects, S2 holds the 1X..4X multiples (3X adder sits between the stages).
module booth_encoder_unit
    import r8_mbe_pkg::sel_t;
#(
    parameter int XW = r8_mbe_pkg::XW,
    parameter int YW = r8_mbe_pkg::YW
)
(
    input  logic clk,
    input  logic rst_n,
    booth_encoder_unit_if.slave bus
);

    localparam int PPW  = XW + 3;
    localparam int NPP  = (YW + 3) / 3;
    localparam int EXTW = 3 * NPP + 1;

    logic           s1_valid;
    logic           s2_valid;
    logic           s2_load;
    logic           s1_advance;
    logic           in_fire;
    logic [XW-1:0]  s1_x;
    sel_t [NPP-1:0] enc_sel;
    sel_t [NPP-1:0] s1_sel;
    sel_t [NPP-1:0] s2_sel;
    logic [PPW-1:0] x1_c, x2_c, x3_c, x4_c;
    logic [PPW-1:0] s2_x1, s2_x2, s2_x3, s2_x4;
    logic [EXTW-1:0] y_ext;

    assign s2_load     = !s2_valid | bus.out_ready;
    assign s1_advance  = s1_valid & s2_load;
    assign bus.in_ready = !s1_valid | s1_advance;
    assign in_fire     = bus.in_valid & bus.in_ready;

    // Bit 0 is the implicit y[-1]; upper pad makes the top digit non-negative
    assign y_ext = {{(EXTW-YW-1){1'b0}}, bus.y_in, 1'b0};

    for (genvar i = 0; i < NPP; i++) begin : g_enc
        booth_encoder u_enc (
            .win (y_ext[3*i +: 4]),
            .sel (enc_sel[i])
        );
    end

    assign x1_c = PPW'(s1_x);
    assign x2_c = x1_c << 1;
    assign x3_c = x1_c + x2_c;
    assign x4_c = x1_c << 2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (bus.flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (bus.in_ready) s1_valid <= bus.in_valid;
            if (s2_load)      s2_valid <= s1_valid;
        end
    end

    // Data registers ignore flush; stale contents are masked by the valid bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_x   <= '0;
            s1_sel <= '0;
            s2_x1  <= '0;
            s2_x2  <= '0;
            s2_x3  <= '0;
            s2_x4  <= '0;
            s2_sel <= '0;
        end else begin
            if (in_fire) begin
                s1_x   <= bus.x_in;
                s1_sel <= enc_sel;
            end
            if (s1_advance) begin
                s2_x1  <= x1_c;
                s2_x2  <= x2_c;
                s2_x3  <= x3_c;
                s2_x4  <= x4_c;
                s2_sel <= s1_sel;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.x_1       = s2_x1;
    assign bus.x_2       = s2_x2;
    assign bus.x_3       = s2_x3;
    assign bus.x_4       = s2_x4;
    assign bus.beu_sel   = s2_sel;

endmodule

// File: tb/tb_booth_encoder_unit.sv
// Directed + random bench for booth_encoder_unit with an in-order scoreboard.
module tb_booth_encoder_unit;
  import r8_mbe_pkg::*;

  localparam int OW = 4 * PPW + NPP * SEL_W;
  localparam int EW = YW + OW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  booth_encoder_unit_if bus ();

  booth_encoder_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int pops = 0;

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic sel_vec_t model_sel(input logic [YW-1:0] y);
    logic [3*NPP:0] ext;
    sel_vec_t v;
    int d;
    int a;
    ext = '0;
    ext[YW:1] = y;
    for (int i = 0; i < NPP; i++) begin
      d = -4 * int'(ext[3*i+3]) + 2 * int'(ext[3*i+2]) + int'(ext[3*i+1]) + int'(ext[3*i]);
      a = (d < 0) ? -d : d;
      v[i] = '0;
      v[i][SEL_NEG] = (d < 0);
      v[i][SEL_4] = (a == 4);
      v[i][SEL_3] = (a == 3);
      v[i][SEL_2] = (a == 2);
      v[i][SEL_1] = (a == 1);
    end
    return v;
  endfunction

  function automatic logic [OW-1:0] model_out(input logic [XW-1:0] x, input logic [YW-1:0] y);
    logic [PPW-1:0] xe;
    xe = PPW'(x);
    return {xe, PPW'(xe * 2), PPW'(xe * 3), PPW'(xe * 4), model_sel(y)};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [XW-1:0] x, input logic [YW-1:0] y);
    exp_q.push_back({y, model_out(x, y)});
  endtask

  task automatic send(input logic [XW-1:0] x, input logic [YW-1:0] y);
    int waited;
    bit done;
    waited = 0;
    done = 0;
    bus.in_valid = 1'b1;
    bus.x_in = x;
    bus.y_in = y;
    while (!done && waited < 50) begin
      @(negedge clk);
      if (bus.in_ready) begin
        push(x, y);
        done = 1;
      end
      @(posedge clk);
      #1;
      waited++;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL send_timeout observed=in_ready=0 expected=1");
    end
  endtask

  task automatic wait_out(input string tag);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.out_valid) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout observed=out_valid=0 expected=1", tag);
    end
  endtask

  // scoreboard: every output transfer is compared against the oldest expectation
  always @(negedge clk) begin
    logic [EW-1:0] e;
    longint sum;
    int nz;
    int m;
    if (rst_n && !bus.flush && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_unexpected observed=%0h expected=none", bus.x_1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", {bus.x_1, bus.x_2, bus.x_3, bus.x_4, bus.beu_sel}, e[OW-1:0]);
        sum = 0;
        nz = 0;
        for (int i = 0; i < NPP; i++) begin
          m = bus.beu_sel[i][SEL_4] ? 4 : bus.beu_sel[i][SEL_3] ? 3 :
              bus.beu_sel[i][SEL_2] ? 2 : bus.beu_sel[i][SEL_1] ? 1 : 0;
          if (bus.beu_sel[i][SEL_NEG]) begin
            if (m == 0) nz++;
            sum -= longint'(m) << (3 * i);
          end else begin
            sum += longint'(m) << (3 * i);
          end
        end
        chk("sb_recompose", sum, e[EW-1:OW]);
        chk("sb_neg_zero", nz, 0);
      end
      pops++;
    end
  end

  initial begin
    sel_vec_t es;
    logic [OW-1:0] snap;
    int n;
    int cyc;
    int sent;
    int pops0;
    bit acc;

    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.x_in = '0;
    bus.y_in = '0;
    bus.out_ready = 1'b0;

    // reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_x", {bus.x_1, bus.x_2, bus.x_3, bus.x_4}, 0);
    chk("rst_sel", bus.beu_sel, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid_after", bus.out_valid, 0);
    @(posedge clk);
    #1;

    // X=1, Y=7: latency and encoding
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.x_in = 24'd1;
    bus.y_in = 24'd7;
    @(negedge clk);
    chk("t1_accept", bus.in_ready, 1);
    push(24'd1, 24'd7);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t1_lat1", bus.out_valid, 0);
    @(negedge clk);
    chk("t1_lat2", bus.out_valid, 1);
    chk("t1_x", {bus.x_1, bus.x_2, bus.x_3, bus.x_4}, {27'd1, 27'd2, 27'd3, 27'd4});
    es = '0;
    es[0] = 5'b1_0001;
    es[1] = 5'b0_0001;
    chk("t1_sel", bus.beu_sel, es);
    @(posedge clk);
    #1;

    // all-ones operands
    send(24'hFFFFFF, 24'hFFFFFF);
    wait_out("t2");
    chk("t2_x3", bus.x_3, 27'h2FFFFFD);
    chk("t2_x4", bus.x_4, 27'h3FFFFFC);
    es = '0;
    es[0] = 5'b1_0001;
    es[8] = 5'b0_0001;
    chk("t2_sel", bus.beu_sel, es);
    @(posedge clk);
    #1;

    // Y=4 gives a -4 digit
    send(24'd5, 24'd4);
    wait_out("t3");
    es = '0;
    es[0] = 5'b1_1000;
    es[1] = 5'b0_0001;
    chk("t3_sel", bus.beu_sel, es);
    chk("t3_x3", bus.x_3, 27'd15);
    @(posedge clk);
    #1;

    // random sweep with random backpressure
    n = 0;
    cyc = 0;
    while (n < 10000 && cyc < 40000) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_valid = 1'b1;
      bus.x_in = 24'($urandom);
      bus.y_in = 24'($urandom);
      @(negedge clk);
      acc = bus.in_ready;
      if (acc) push(bus.x_in, bus.y_in);
      @(posedge clk);
      #1;
      if (acc) n++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int w = 0; w < 20 && exp_q.size() != 0; w++) begin
      @(posedge clk);
      #1;
    end
    chk("sweep_count", n, 10000);
    chk("sweep_drain", exp_q.size(), 0);

    // 5 back-to-back inputs with out_ready low for 4 cycles
    sent = 0;
    pops0 = pops;
    snap = '0;
    for (int c = 0; c < 40; c++) begin
      if (sent >= 5 && exp_q.size() == 0) break;
      bus.out_ready = (c >= 4);
      bus.in_valid = (sent < 5);
      bus.x_in = 24'(100 + sent);
      bus.y_in = 24'($urandom);
      @(negedge clk);
      if (c == 2) begin
        chk("stall_in_ready", bus.in_ready, 0);
        chk("stall_accepts", sent, 2);
        snap = {bus.x_1, bus.x_2, bus.x_3, bus.x_4, bus.beu_sel};
      end
      if (c == 3) begin
        chk("stall_hold", {bus.x_1, bus.x_2, bus.x_3, bus.x_4, bus.beu_sel}, snap);
        chk("stall_in_ready_hold", bus.in_ready, 0);
        chk("stall_out_valid", bus.out_valid, 1);
      end
      if (c >= 4 && c <= 8) chk("stall_stream", bus.out_valid, 1);
      acc = bus.in_valid & bus.in_ready;
      if (acc) push(bus.x_in, bus.y_in);
      @(posedge clk);
      #1;
      if (acc) sent++;
    end
    bus.in_valid = 1'b0;
    chk("stall_sent", sent, 5);
    chk("stall_pops", pops - pops0, 5);

    // flush with both stages full and an input offered
    bus.out_ready = 1'b0;
    send(24'h11, 24'h22);
    send(24'h33, 24'h44);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.x_in = 24'h55;
    bus.y_in = 24'h66;
    bus.flush = 1'b1;
    @(negedge clk);
    chk("fl_pre_full", bus.out_valid, 1);
    chk("fl_pre_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("fl_out_valid", bus.out_valid, 0);
    chk("fl_in_ready", bus.in_ready, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("fl_quiet", bus.out_valid, 0);
    end
    @(posedge clk);
    #1;

    // asynchronous reset mid-stream
    bus.out_ready = 1'b1;
    send(24'hABC, 24'h123);
    send(24'hDEF, 24'h456);
    chk("ar_pre", bus.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", bus.out_valid, 0);
    chk("ar_x", {bus.x_1, bus.x_2, bus.x_3, bus.x_4}, 0);
    chk("ar_sel", bus.beu_sel, 0);
    exp_q.delete();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.x_in = 24'h123456;
    bus.y_in = 24'hABCDEF;
    @(negedge clk);
    chk("ar_accept", bus.in_ready, 1);
    push(24'h123456, 24'hABCDEF);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("ar_lat1", bus.out_valid, 0);
    @(negedge clk);
    chk("ar_lat2", bus.out_valid, 1);
    chk("ar_x3", bus.x_3, 27'h369D02);
    chk("ar_sel_post", bus.beu_sel, model_sel(24'hABCDEF));
    @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    #1;
    chk("final_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
